// File: rtl/pmic_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmic_pwm_pkg
// Brief    : Shared state encoding, default period and duty clamp helper
//            for the buck-stage PWM dead-time generator.
// Revision : 1.0
// ============================================================================
package pmic_pwm_pkg;

    localparam int unsigned c_PERIOD_DEF = 15;

    typedef logic [2:0] pwm_state_t;

    localparam pwm_state_t c_IDLE  = 3'd0;
    localparam pwm_state_t c_DT_LH = 3'd1;
    localparam pwm_state_t c_HS_ON = 3'd2;
    localparam pwm_state_t c_DT_HL = 3'd3;
    localparam pwm_state_t c_LS_ON = 3'd4;
    localparam pwm_state_t c_FAULT = 3'd5;

    // Requested on-time can never exceed one full period (PERIOD+1 clocks).
    function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                               input logic [31:0] period);
        if (duty > period + 32'd1)
            return period + 32'd1;
        else
            return duty;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deadtime_timer.sv
`default_nettype none
// ============================================================================
// Module   : deadtime_timer
// Brief    : Loadable down-counter for the gate dead time; a zero load value
//            is promoted to one so the gap can never vanish.
// Revision : 1.0
// ============================================================================
module deadtime_timer #(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    output logic            expired
);

    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_load_val;

    assign w_load_val = (load_val == '0) ? DT_W'(1) : load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (load)
            r_cnt <= w_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Expiry on the last dead cycle lets the FSM leave exactly on time.
    assign expired = (r_cnt == DT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_deadtime_gen
// Brief    : Duty compare against the period down-counter, complementary
//            gate drive with programmable dead time and latched OCP fault.
// Revision : 1.0
// ============================================================================
module pwm_deadtime_gen
    import pmic_pwm_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int PERIOD = c_PERIOD_DEF,
    parameter int DUTY_W = 5,
    parameter int DT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              run,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic [DT_W-1:0]   dt_cfg,
    input  logic              ocp,
    input  logic              fault_clr,
    output logic              gate_hs,
    output logic              gate_ls,
    output logic              fault,
    output logic [DUTY_W-1:0] duty_active,
    output logic              period_start
);

    pwm_state_t        r_state;
    pwm_state_t        w_state_nxt;
    logic              w_load_dt;
    logic              w_dt_expired;
    logic              w_raw_on;
    logic              w_cnt_zero;
    logic [CNT_W-1:0]  w_phase;
    logic [DUTY_W-1:0] w_duty_clamp;
    logic [DUTY_W-1:0] r_duty;
    logic              r_gate_hs;
    logic              r_gate_ls;
    logic              r_fault;
    logic              r_period_start;

    assign w_cnt_zero   = (count_in == '0);
    assign w_phase      = CNT_W'(PERIOD) - count_in;
    assign w_raw_on     = (w_phase < CNT_W'(r_duty));
    assign w_duty_clamp = DUTY_W'(clamp_duty(32'(duty_in), 32'(PERIOD)));

    deadtime_timer #(
        .DT_W (DT_W)
    ) u_deadtime_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load_dt),
        .load_val (dt_cfg),
        .expired  (w_dt_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load_dt   = 1'b0;
        if (ocp) begin
            w_state_nxt = c_FAULT;
        end else if (r_state == c_FAULT) begin
            if (fault_clr && !run)
                w_state_nxt = c_IDLE;
        end else if (!run) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_state_nxt = w_raw_on ? c_DT_LH : c_DT_HL;
                    w_load_dt   = 1'b1;
                end
                c_HS_ON: begin
                    if (!w_raw_on) begin
                        w_state_nxt = c_DT_HL;
                        w_load_dt   = 1'b1;
                    end
                end
                c_LS_ON: begin
                    if (w_raw_on) begin
                        w_state_nxt = c_DT_LH;
                        w_load_dt   = 1'b1;
                    end
                end
                // A raw edge inside a gap restarts the gap toward the new side.
                c_DT_LH: begin
                    if (!w_raw_on) begin
                        w_state_nxt = c_DT_HL;
                        w_load_dt   = 1'b1;
                    end else if (w_dt_expired) begin
                        w_state_nxt = c_HS_ON;
                    end
                end
                c_DT_HL: begin
                    if (w_raw_on) begin
                        w_state_nxt = c_DT_LH;
                        w_load_dt   = 1'b1;
                    end else if (w_dt_expired) begin
                        w_state_nxt = c_LS_ON;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Gates follow the next-state decode so they match the state register
    // cycle for cycle while still coming straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_gate_hs      <= 1'b0;
            r_gate_ls      <= 1'b0;
            r_fault        <= 1'b0;
            r_duty         <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gate_hs      <= (w_state_nxt == c_HS_ON);
            r_gate_ls      <= (w_state_nxt == c_LS_ON);
            r_fault        <= (w_state_nxt == c_FAULT);
            r_period_start <= w_cnt_zero;
            if (w_cnt_zero || (r_state == c_IDLE))
                r_duty <= w_duty_clamp;
        end
    end

    assign gate_hs      = r_gate_hs;
    assign gate_ls      = r_gate_ls;
    assign fault        = r_fault;
    assign duty_active  = r_duty;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_deadtime_gen
// Brief    : Directed and randomized checks of pwm_deadtime_gen against a
//            side/gap reference model.
// Revision : 1.0
// ============================================================================
module tb_pwm_deadtime_gen;

    localparam int CNT_W  = 32;
    localparam int PERIOD = 15;
    localparam int DUTY_W = 5;
    localparam int DT_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CNT_W-1:0]  count_in;
    logic              run;
    logic [DUTY_W-1:0] duty_in;
    logic [DT_W-1:0]   dt_cfg;
    logic              ocp;
    logic              fault_clr;
    logic              gate_hs;
    logic              gate_ls;
    logic              fault;
    logic [DUTY_W-1:0] duty_active;
    logic              period_start;

    int checks = 0;
    int errors = 0;

    // Reference model: which side the bridge is heading to (0 none, 1 HS, 2 LS)
    // and how many dead cycles remain before that side may conduct.
    int m_target, m_gap, m_fault, m_duty, m_ps;
    int cnt;

    pwm_deadtime_gen #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD),
        .DUTY_W (DUTY_W),
        .DT_W   (DT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count_in     (count_in),
        .run          (run),
        .duty_in      (duty_in),
        .dt_cfg       (dt_cfg),
        .ocp          (ocp),
        .fault_clr    (fault_clr),
        .gate_hs      (gate_hs),
        .gate_ls      (gate_ls),
        .fault        (fault),
        .duty_active  (duty_active),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_target = 0; m_gap = 0; m_fault = 0; m_duty = 0; m_ps = 0;
    endtask

    task automatic model_tick();
        int phase, raw, want, dtv, clampd, idle;
        phase  = PERIOD - int'(count_in);
        raw    = (phase < m_duty) ? 1 : 0;
        want   = raw ? 1 : 2;
        dtv    = (dt_cfg == 0) ? 1 : int'(dt_cfg);
        clampd = (int'(duty_in) > PERIOD + 1) ? PERIOD + 1 : int'(duty_in);
        idle   = (m_target == 0 && m_fault == 0) ? 1 : 0;
        if (ocp) begin
            m_fault = 1; m_target = 0; m_gap = 0;
        end else if (m_fault != 0) begin
            if (fault_clr && !run) m_fault = 0;
        end else if (!run) begin
            m_target = 0; m_gap = 0;
        end else if (m_target != want) begin
            m_target = want; m_gap = dtv;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        m_ps = (count_in == 0) ? 1 : 0;
        if (count_in == 0 || idle != 0) m_duty = clampd;
    endtask

    task automatic check_outputs();
        chk("gate_hs", gate_hs, (m_target == 1 && m_gap == 0) ? 1 : 0);
        chk("gate_ls", gate_ls, (m_target == 2 && m_gap == 0) ? 1 : 0);
        chk("fault", fault, m_fault);
        chk("duty_active", duty_active, m_duty);
        chk("period_start", period_start, m_ps);
        chk("interlock", gate_hs & gate_ls, 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_tick();
        #1;
        cnt = (cnt == 0) ? PERIOD : cnt - 1;
        count_in = cnt;
        check_outputs();
    endtask

    task automatic measure(output int hs, output int ls, output int ps);
        hs = 0; ls = 0; ps = 0;
        for (int i = 0; i <= PERIOD; i++) begin
            step();
            hs += int'(gate_hs);
            ls += int'(gate_ls);
            ps += int'(period_start);
        end
    endtask

    task automatic wait_hs();
        int n;
        n = 0;
        while (!gate_hs && n < 64) begin
            step();
            n++;
        end
        chk("wait_hs_timeout", gate_hs, 1);
    endtask

    initial begin
        int hs, ls, ps, guard;
        reset = 1'b1; run = 1'b0; ocp = 1'b0; fault_clr = 1'b0;
        duty_in = 5'd8; dt_cfg = 4'd2;
        cnt = PERIOD; count_in = cnt;
        model_reset();
        repeat (3) step();
        reset = 1'b0;

        // Steady state
        run = 1'b1;
        repeat (48) step();
        measure(hs, ls, ps);
        chk("steady_hs", hs, 6); chk("steady_ls", ls, 6); chk("steady_ps", ps, 1);

        // Duty extremes
        duty_in = 5'd0;
        repeat (40) step();
        measure(hs, ls, ps);
        chk("duty0_hs", hs, 0); chk("duty0_ls", ls, 16);
        duty_in = 5'd20;
        repeat (40) step();
        chk("duty_clamp", duty_active, 16);
        measure(hs, ls, ps);
        chk("duty20_hs", hs, 16); chk("duty20_ls", ls, 0);

        // Duty update mid-period is deferred to the next period start
        duty_in = 5'd8;
        repeat (40) step();
        guard = 0;
        while (cnt != 10 && guard < 32) begin step(); guard++; end
        duty_in = 5'd4;
        guard = 0;
        while (cnt != 0 && guard < 32) begin
            step();
            chk("duty_hold", duty_active, 8);
            guard++;
        end
        step();
        chk("duty_update", duty_active, 4);
        measure(hs, ls, ps);
        chk("duty4_hs", hs, 2);

        // Minimum dead time
        duty_in = 5'd8; dt_cfg = 4'd0;
        repeat (40) step();
        measure(hs, ls, ps);
        chk("dt0_hs", hs, 7); chk("dt0_ls", ls, 7);

        // Raw pulse shorter than the gap: reload, no HS pulse
        duty_in = 5'd2; dt_cfg = 4'd3;
        repeat (40) step();
        measure(hs, ls, ps);
        chk("glitch_hs", hs, 0); chk("glitch_ls", ls, 11);

        // Fault handling
        duty_in = 5'd8; dt_cfg = 4'd2;
        repeat (40) step();
        wait_hs();
        ocp = 1'b1; step(); ocp = 1'b0;
        chk("ocp_fault", fault, 1); chk("ocp_hs_off", gate_hs, 0);
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        chk("clr_run_ignored", fault, 1);
        run = 1'b0; ocp = 1'b1; fault_clr = 1'b1; step();
        chk("ocp_wins", fault, 1);
        ocp = 1'b0; step(); fault_clr = 1'b0;
        chk("clr_ok", fault, 0);
        run = 1'b1;
        repeat (40) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            run       = ($urandom_range(0, 99) < 92);
            ocp       = ($urandom_range(0, 99) < 1);
            fault_clr = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 5) duty_in = DUTY_W'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 3) dt_cfg  = DT_W'($urandom_range(0, 15));
            step();
        end

        // Asynchronous reset while HS conducts
        ocp = 1'b0; fault_clr = 1'b0; run = 1'b0;
        step(); fault_clr = 1'b1; step(); fault_clr = 1'b0;
        run = 1'b1; duty_in = 5'd12; dt_cfg = 4'd1;
        repeat (40) step();
        wait_hs();
        #3;
        reset = 1'b1;
        #1;
        chk("async_hs", gate_hs, 0);
        chk("async_ls", gate_ls, 0);
        chk("async_fault", fault, 0);
        model_reset();
        run = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        chk("post_reset_hs", gate_hs, 0);
        chk("post_reset_ls", gate_ls, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
